// File: rtl/proc_core.sv
// Single-cycle 32-bit core: PC register plus decode/ALU datapath around an external
// regfile, instruction ROM and data RAM. Define OVF_EN to redirect signed-overflow results to r30.
module proc_core #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  logic [31:0] pc_q, pc_d;

  logic [4:0]  op, rd, rs, rt, shamt, aluop;
  logic [31:0] imm_sx, t_zx, pc_plus1, branch_pc;
  logic [31:0] add_res, sub_res, addi_res;
  logic        add_ovf, sub_ovf, addi_ovf;
  logic        we_raw, wren_raw;
  logic        unused_bits;

  assign op    = q_imem[31:27];
  assign rd    = q_imem[26:22];
  assign rs    = q_imem[21:17];
  assign rt    = q_imem[16:12];
  assign shamt = q_imem[11:7];
  assign aluop = q_imem[6:2];
  assign unused_bits = ^q_imem[1:0];

  assign imm_sx    = {{15{q_imem[16]}}, q_imem[16:0]};
  assign t_zx      = {5'b00000, q_imem[26:0]};
  assign pc_plus1  = pc_q + 32'd1;
  assign branch_pc = pc_plus1 + imm_sx;

  // Signed overflow: operands agree in sign (after negating b for sub) but the result does not.
  assign add_res  = data_readRegA + data_readRegB;
  assign sub_res  = data_readRegA - data_readRegB;
  assign addi_res = data_readRegA + imm_sx;
  assign add_ovf  = (data_readRegA[31] == data_readRegB[31]) && (add_res[31] != data_readRegA[31]);
  assign sub_ovf  = (data_readRegA[31] != data_readRegB[31]) && (sub_res[31] != data_readRegA[31]);
  assign addi_ovf = (data_readRegA[31] == imm_sx[31]) && (addi_res[31] != data_readRegA[31]);

  always_comb begin
    pc_d          = pc_plus1;
    ctrl_readRegA = rs;
    ctrl_readRegB = rt;
    ctrl_writeReg = rd;
    data_writeReg = 32'd0;
    we_raw        = 1'b0;
    wren_raw      = 1'b0;
    address_dmem  = addi_res;
    data          = data_readRegB;

    unique case (op)
      OP_RTYPE: begin
        we_raw = 1'b1;
        unique case (aluop)
          ALU_ADD: begin
            data_writeReg = add_res;
`ifdef OVF_EN
            if (add_ovf) begin
              ctrl_writeReg = 5'd30;
              data_writeReg = 32'd1;
            end
`endif
          end
          ALU_SUB: begin
            data_writeReg = sub_res;
`ifdef OVF_EN
            if (sub_ovf) begin
              ctrl_writeReg = 5'd30;
              data_writeReg = 32'd3;
            end
`endif
          end
          ALU_AND: data_writeReg = data_readRegA & data_readRegB;
          ALU_OR:  data_writeReg = data_readRegA | data_readRegB;
          ALU_SLL: data_writeReg = data_readRegA << shamt;
          ALU_SRA: data_writeReg = $signed(data_readRegA) >>> shamt;
          default: we_raw = 1'b0;
        endcase
      end
      OP_ADDI: begin
        we_raw        = 1'b1;
        data_writeReg = addi_res;
`ifdef OVF_EN
        if (addi_ovf) begin
          ctrl_writeReg = 5'd30;
          data_writeReg = 32'd2;
        end
`endif
      end
      OP_LW: begin
        we_raw        = 1'b1;
        data_writeReg = q_dmem;
      end
      OP_SW: begin
        ctrl_readRegB = rd;
        wren_raw      = 1'b1;
      end
      OP_J: pc_d = t_zx;
      OP_JAL: begin
        we_raw        = 1'b1;
        ctrl_writeReg = 5'd31;
        data_writeReg = pc_plus1;
        pc_d          = t_zx;
      end
      OP_JR: begin
        ctrl_readRegA = rd;
        pc_d          = data_readRegA;
      end
      OP_BNE: begin
        ctrl_readRegA = rd;
        ctrl_readRegB = rs;
        if (data_readRegA != data_readRegB) pc_d = branch_pc;
      end
      OP_BLT: begin
        ctrl_readRegA = rd;
        ctrl_readRegB = rs;
        if ($signed(data_readRegA) < $signed(data_readRegB)) pc_d = branch_pc;
      end
      OP_BEX: begin
        ctrl_readRegA = 5'd30;
        if (data_readRegA != 32'd0) pc_d = t_zx;
      end
      OP_SETX: begin
        we_raw        = 1'b1;
        ctrl_writeReg = 5'd30;
        data_writeReg = t_zx;
      end
      default: ;
    endcase
  end

  // r0 is hardwired: suppress any write targeting it. Reset also blocks all writes.
  assign ctrl_writeEnable = we_raw && (ctrl_writeReg != 5'd0) && reset;
  assign wren             = wren_raw && reset;
  assign address_imem     = pc_q;

  always_ff @(posedge clock) begin
    if (!reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

`ifndef OVF_EN
  logic unused_ovf;
  assign unused_ovf = add_ovf ^ sub_ovf ^ addi_ovf;
`endif

endmodule

// File: tb/tb_proc_core.sv
// Directed program bench for proc_core: models ROM, regfile and RAM around the core,
// tracks the PC trace against an expected queue, then checks final register contents.
module tb_proc_core;

  logic        clock;
  logic        reset;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom [0:63];
  logic [31:0] rf  [0:31];
  logic [31:0] ram [0:63];
  logic [31:0] exp_q [$];

  proc_core #(.RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // environment models
  assign q_imem        = rom[address_imem[5:0]];
  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];
  assign q_dmem        = ram[address_dmem[5:0]];

  always @(posedge clock) begin
    if (ctrl_writeEnable === 1'b1) rf[ctrl_writeReg] <= data_writeReg;
    if (wren === 1'b1) ram[address_dmem[5:0]] <= data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt,
                                        input int shamt, input int aluop);
    enc_r = {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'(shamt), 5'(aluop), 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rd, input int rs, input int imm);
    enc_i = {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic logic [31:0] enc_t(input int op, input int t);
    enc_t = {5'(op), 27'(t)};
  endfunction

  task automatic load_program();
    for (int i = 0; i < 64; i++) begin rom[i] = 32'd0; ram[i] = 32'd0; end
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rom[0]  = enc_i(5, 1, 0, 5);          // addi r1,r0,5
    rom[1]  = enc_i(5, 2, 0, -3);         // addi r2,r0,-3
    rom[2]  = enc_r(3, 1, 2, 0, 0);       // add r3,r1,r2
    rom[3]  = enc_t(3, 10);               // jal 10
    rom[4]  = enc_t(1, 20);               // j 20
    rom[10] = enc_r(4, 1, 2, 0, 1);       // sub r4,r1,r2
    rom[11] = enc_r(5, 1, 0, 2, 4);       // sll r5,r1,2
    rom[12] = enc_i(7, 1, 0, 4);          // sw r1,4(r0)
    rom[13] = enc_i(8, 6, 0, 4);          // lw r6,4(r0)
    rom[14] = enc_i(4, 31, 0, 0);         // jr r31
    rom[20] = enc_i(2, 1, 2, 2);          // bne r1,r2,+2 (taken)
    rom[21] = enc_i(5, 8, 0, 1);
    rom[22] = enc_i(5, 8, 0, 1);
    rom[23] = enc_i(6, 2, 1, 1);          // blt r2,r1,+1 (taken)
    rom[24] = enc_i(5, 9, 0, 1);
    rom[25] = enc_i(2, 1, 1, 3);          // bne r1,r1,+3 (not taken)
    rom[26] = enc_t(21, 7);               // setx 7
    rom[27] = enc_t(22, 40);              // bex 40
    for (int i = 28; i < 40; i++) rom[i] = enc_i(5, 10, 0, 1);
    rom[40] = enc_i(5, 11, 0, 1);         // r11 = 1
    rom[41] = enc_r(11, 11, 0, 30, 4);    // r11 = 0x40000000
    rom[42] = enc_i(5, 13, 0, 1);         // r13 = 1
    rom[43] = enc_r(12, 11, 13, 0, 1);    // r12 = 0x3FFFFFFF
    rom[44] = enc_r(12, 12, 11, 0, 0);    // r12 = 0x7FFFFFFF
    rom[45] = enc_r(7, 12, 12, 0, 0);     // add r7: overflows
    rom[46] = enc_i(5, 0, 0, 9);          // addi r0,r0,9
    rom[47] = enc_r(14, 2, 0, 1, 5);      // sra r14,r2,1
    rom[48] = enc_r(15, 1, 2, 0, 2);      // and
    rom[49] = enc_r(16, 1, 2, 0, 3);      // or
    rom[50] = enc_r(17, 1, 2, 0, 6);      // bad aluop: no write
    rom[51] = {5'b11111, 5'd18, 22'h0};   // unlisted op: nop
    rom[52] = enc_t(1, 52);               // halt loop
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(32'(i));
  endtask

  initial begin
    logic [31:0] exp_pc;
    reset = 1'b0;
    load_program();

    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      @(negedge clock);
      check("reset_pc", address_imem, 32'd0);
      check("reset_we", {31'd0, ctrl_writeEnable}, 32'd0);
      check("reset_wren", {31'd0, wren}, 32'd0);
    end
    reset = 1'b1;

    push_range(0, 3);
    push_range(10, 14);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd23);
    push_range(25, 27);
    push_range(40, 52);
    exp_q.push_back(32'd52);
    exp_q.push_back(32'd52);

    while (exp_q.size() > 0) begin
      exp_pc = exp_q.pop_front();
      check("pc_trace", address_imem, exp_pc);
      check("wren_only_sw", {31'd0, wren}, {31'd0, (exp_pc == 32'd12)});
      if (exp_pc == 32'd12) begin
        check("sw_addr", address_dmem, 32'd4);
        check("sw_data", data, 32'd5);
      end
      @(posedge clock);
      @(negedge clock);
    end

    check("r0",  rf[0],  32'd0);
    check("r1",  rf[1],  32'd5);
    check("r2",  rf[2],  32'hFFFF_FFFD);
    check("r3",  rf[3],  32'd2);
    check("r4",  rf[4],  32'd8);
    check("r5",  rf[5],  32'd20);
    check("r6",  rf[6],  32'd5);
    check("ram4", ram[4], 32'd5);
    check("r8_skipped", rf[8], 32'd0);
    check("r9_skipped", rf[9], 32'd0);
    check("r10_skipped", rf[10], 32'd0);
    check("r31_jal", rf[31], 32'd4);
    check("r12_max", rf[12], 32'h7FFF_FFFF);
`ifdef OVF_EN
    check("r30_ovf", rf[30], 32'd1);
    check("r7_ovf",  rf[7],  32'd0);
`else
    check("r30_setx", rf[30], 32'd7);
    check("r7_wrap",  rf[7],  32'hFFFF_FFFE);
`endif
    check("r14_sra", rf[14], 32'hFFFF_FFFE);
    check("r15_and", rf[15], 32'd5);
    check("r16_or",  rf[16], 32'hFFFF_FFFD);
    check("r17_badalu", rf[17], 32'd0);
    check("r18_badop",  rf[18], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
